tm1638_responder: RTL

- Device-side model of the TM1638 serial interface: the chip end of the STB/CLK/DIO link that our host controller drives.
- Decodes data, address and display-control commands, stores the 16-byte display RAM, and returns 4 key-scan bytes on a read command.
- Used as an on-FPGA loopback target for host bring-up and as a synthesizable bench partner.
- Runs entirely in the `clk` domain; the serial inputs are oversampled.

---
 rtl/tm1638_responder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tm1638_responder : device-side TM1638 STB/CLK/DIO serial endpoint         |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tm1638_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_KEY_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stb,
  input  logic                       sclk,
  input  logic                       dio_in,
  output logic                       dio_out,
  output logic                       dio_oe,
  input  logic [8*NUM_KEY_BYTES-1:0] key_bits,
  input  logic [3:0]                 rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       disp_on,
  output logic [2:0]                 brightness,
  output logic                       wr_strobe,
  output logic [3:0]                 wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       cmd_err
);

  localparam int KW = 8 * NUM_KEY_BYTES;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  logic [SYNC_STAGES-1:0] stb_sync_q, sclk_sync_q, dio_sync_q;
  logic                   stb_prev_q, sclk_prev_q;
  logic                   w_stb, w_sclk, w_dio;
  logic                   w_stb_rise, w_stb_fall, w_sclk_rise, w_sclk_fall;

  logic [2:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    addr_q, addr_d;
  logic          rd_mode_q, rd_mode_d;
  logic          fixed_q, fixed_d;
  logic          disp_on_q, disp_on_d;
  logic [2:0]    bright_q, bright_d;
  logic [KW-1:0] key_sr_q, key_sr_d;
  logic          dio_out_q, dio_out_d;
  logic          dio_oe_q, dio_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          cmd_err_q, cmd_err_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    ram_q [16];
  logic          w_ram_we;
  logic [7:0]    w_byte;
  logic          w_byte_done;

  assign w_stb       = stb_sync_q[SYNC_STAGES-1];
  assign w_sclk      = sclk_sync_q[SYNC_STAGES-1];
  assign w_dio       = dio_sync_q[SYNC_STAGES-1];
  assign w_stb_rise  = w_stb & ~stb_prev_q;
  assign w_stb_fall  = ~w_stb & stb_prev_q;
  assign w_sclk_rise = w_sclk & ~sclk_prev_q;
  assign w_sclk_fall = ~w_sclk & sclk_prev_q;
  assign w_byte      = {w_dio, shift_q[7:1]};
  assign w_byte_done = w_sclk_rise && (bitcnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    rd_mode_d   = rd_mode_q;
    fixed_d     = fixed_q;
    disp_on_d   = disp_on_q;
    bright_d    = bright_q;
    key_sr_d    = key_sr_q;
    dio_out_d   = dio_out_q;
    dio_oe_d    = dio_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_err_d   = 1'b0;
    w_ram_we    = 1'b0;
    // A stb rise wins over a coincident 8th clock edge, so that byte is dropped.
    if (w_stb_rise) begin
      state_d   = S_IDLE;
      bitcnt_d  = 3'd0;
      dio_oe_d  = 1'b0;
      dio_out_d = 1'b1;
    end else if (w_stb_fall) begin
      state_d  = S_CMD;
      bitcnt_d = 3'd0;
    end else if (state_q != S_IDLE) begin
      if (w_sclk_rise) begin
        shift_d  = w_byte;
        bitcnt_d = bitcnt_q + 3'd1;
      end
      if (w_byte_done) begin
        case (state_q)
          S_CMD: begin
            case (w_byte[7:6])
              2'b01: begin
                rd_mode_d = w_byte[1];
                fixed_d   = w_byte[2];
                if (w_byte[1]) begin
                  key_sr_d = key_bits;
                  state_d  = S_RDATA;
                end else begin
                  state_d  = S_IGNORE;
                end
              end
              2'b11: begin
                addr_d  = w_byte[3:0];
                state_d = rd_mode_q ? S_IGNORE : S_WDATA;
              end
              2'b10: begin
                disp_on_d = w_byte[3];
                bright_d  = w_byte[2:0];
                state_d   = S_IGNORE;
              end
              default: begin
                cmd_err_d = 1'b1;
                state_d   = S_IGNORE;
              end
            endcase
          end
          S_WDATA: begin
            w_ram_we    = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = w_byte;
            if (!fixed_q) addr_d = addr_q + 4'd1;
          end
          default: ;
        endcase
      end
      // Zeros shift in behind the key bytes, so the tail reads as 0.
      if ((state_q == S_RDATA) && w_sclk_fall) begin
        dio_oe_d  = 1'b1;
        dio_out_d = key_sr_q[0];
        key_sr_d  = {1'b0, key_sr_q[KW-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // stb sync resets low so a host already holding stb low cannot start a frame.
      stb_sync_q  <= '0;
      stb_prev_q  <= 1'b0;
      sclk_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      dio_sync_q  <= '0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      addr_q      <= 4'd0;
      rd_mode_q   <= 1'b0;
      fixed_q     <= 1'b0;
      disp_on_q   <= 1'b0;
      bright_q    <= 3'd0;
      key_sr_q    <= '0;
      dio_out_q   <= 1'b1;
      dio_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      cmd_err_q   <= 1'b0;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
    end else begin
      stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], stb};
      stb_prev_q  <= w_stb;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sclk_prev_q <= w_sclk;
      dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio_in};
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rd_mode_q   <= rd_mode_d;
      fixed_q     <= fixed_d;
      disp_on_q   <= disp_on_d;
      bright_q    <= bright_d;
      key_sr_q    <= key_sr_d;
      dio_out_q   <= dio_out_d;
      dio_oe_q    <= dio_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_err_q   <= cmd_err_d;
      rd_data_q   <= ram_q[rd_addr];
      if (w_ram_we) ram_q[addr_q] <= w_byte;
    end
  end

  assign dio_out    = dio_out_q;
  assign dio_oe     = dio_oe_q;
  assign rd_data    = rd_data_q;
  assign disp_on    = disp_on_q;
  assign brightness = bright_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cmd_err    = cmd_err_q;

endmodule
`default_nettype wire
